uart_tx_fifo_reader: RTL and testbench

- Read-side consumer of the UART TX byte FIFO. It pops one byte at a time and serialises each byte onto txd as an 8-bit LSB-first UART frame: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Sits between the TX FIFO (fed by the Wishbone/CPU side) and the pad.
- Baud rate is set at runtime by a clock divisor.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx_fifo_reader.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
//   uart_state_e   : frame-level state encoding
//   UART_DATA_BITS : data bits per frame (LSB first)
//   IDLE_LEVEL     : line level while idle and during stop bits
//   START_LEVEL    : line level of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        IDLE_LEVEL     = 1'b1;
    localparam logic        START_LEVEL    = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..div-1 and wraps; tick is high in the last
// cycle of every bit period. Holding clear keeps the counter at 0 so the
// first period after clear drops lasts exactly div cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : hold counter at zero (no tick while asserted)
//   div   : clocks per bit, must be >= 1
//   tick  : last cycle of the current bit period
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = !clear && (cnt == div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains the TX byte FIFO. Pops one byte while idle
// and sends it as start, 8 data bits LSB first, optional parity, then
// STOP_BITS stop bits. The divisor is sampled at pop time so clk_div may
// change freely while a frame is on the line.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   enable     : allow new frames to start (never aborts a frame)
//   clk_div    : clocks per bit, 0 treated as 1
//   fifo_empty : FIFO has no data
//   fifo_data  : FIFO head byte, valid in the pop cycle
//   fifo_pop   : single-cycle pop strobe
//   txd        : serial output, idle high
//   busy       : frame in progress
//   done       : one-cycle pulse in the first idle cycle after a frame
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_pop,
    output logic             txd,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);

    uart_state_e      state, state_nxt;
    logic [7:0]       shift_reg;
    logic             parity_acc;
    logic [2:0]       bit_idx;
    logic             stop_cnt;
    logic [DIV_W-1:0] div_q;
    logic             baud_clear;
    logic             tick;
    logic             frame_end;

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        txd        = IDLE_LEVEL;
        baud_clear = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                // Timer held at zero so the start bit gets a full period.
                baud_clear = 1'b1;
                if (enable && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                txd = START_LEVEL;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                txd = shift_reg[0];
                if (tick && bit_idx == LAST_BIT) begin
                    state_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                txd = parity_acc ^ PARITY_ODD;
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                txd = IDLE_LEVEL;
                if (tick && stop_cnt == STOP_LAST) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            parity_acc <= 1'b0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            div_q      <= DIV_W'(1);
            done       <= 1'b0;
        end else begin
            done <= frame_end;
            if (fifo_pop) begin
                shift_reg  <= fifo_data;
                div_q      <= (clk_div == '0) ? DIV_W'(1) : clk_div;
                parity_acc <= 1'b0;
                bit_idx    <= '0;
                stop_cnt   <= 1'b0;
            end
            if (state == DATA && tick) begin
                shift_reg  <= {1'b0, shift_reg[7:1]};
                parity_acc <= parity_acc ^ shift_reg[0];
                bit_idx    <= bit_idx + 3'd1;
            end
            if (state == STOP && tick) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: a default-configured instance fed
// by a small FIFO model, plus a parity/two-stop-bit instance fed directly.
module tb_uart_tx_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] clk_div;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_pop, txd, busy, done;

    logic        p_enable;
    logic [15:0] p_clk_div;
    logic        p_empty;
    logic [7:0]  p_byte;
    logic [7:0]  p_data;
    logic        p_pop, p_txd, p_busy, p_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic [3:0] wr = 4'd0;
    logic [3:0] rd = 4'd0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr == rd);
    assign fifo_data  = fifo_pop ? mem[rd] : 8'h00;
    assign p_data     = p_pop ? p_byte : 8'h00;

    always @(posedge clk) if (fifo_pop) rd <= rd + 4'd1;

    uart_tx_fifo_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clk_div    (clk_div),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    uart_tx_fifo_reader #(
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0),
        .STOP_BITS  (2),
        .DIV_W      (16)
    ) dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (p_enable),
        .clk_div    (p_clk_div),
        .fifo_empty (p_empty),
        .fifo_data  (p_data),
        .fifo_pop   (p_pop),
        .txd        (p_txd),
        .busy       (p_busy),
        .done       (p_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr] = b;
        wr = wr + 4'd1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int div, input bit par,
                                     input bit odd, input int i);
        int k;
        k = (i - 1) / div;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par && k == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    task automatic wait_pop(input int w, output bit ok);
        int n;
        n = 0;
        #1;
        while (!(w == 1 ? p_pop : fifo_pop) && n < 200) begin
            step();
            n++;
        end
        ok = (w == 1) ? p_pop : fifo_pop;
        if (!ok) check("pop_timeout", 32'd0, 32'd1);
    endtask

    // Called in the pop cycle; returns in the done cycle.
    task automatic frame(input int w, input logic [7:0] b, input int div, input bit par,
                         input bit odd, input int stops, input int mid_div, input bit mid_dis);
        int len;
        len = div * (9 + int'(par) + stops);
        check($sformatf("pop_%0h", b), {31'd0, (w == 1) ? p_pop : fifo_pop}, 32'd1);
        for (int i = 1; i <= len; i++) begin
            step();
            if (i == 1 && w == 1) p_empty = 1'b1;
            if (i == 3 && mid_div >= 0) clk_div = 16'(mid_div);
            if (i == 3 && mid_dis) enable = 1'b0;
            check($sformatf("txd_%0h_%0d", b, i), {31'd0, (w == 1) ? p_txd : txd},
                  {31'd0, exp_bit(b, div, par, odd, i)});
            check($sformatf("busy_%0h_%0d", b, i), {31'd0, (w == 1) ? p_busy : busy}, 32'd1);
            check($sformatf("nopop_%0h_%0d", b, i), {31'd0, (w == 1) ? p_pop : fifo_pop}, 32'd0);
            check($sformatf("nodone_%0h_%0d", b, i), {31'd0, (w == 1) ? p_done : done}, 32'd0);
        end
        step();
        check($sformatf("done_%0h", b), {31'd0, (w == 1) ? p_done : done}, 32'd1);
        check($sformatf("idle_busy_%0h", b), {31'd0, (w == 1) ? p_busy : busy}, 32'd0);
        check($sformatf("idle_txd_%0h", b), {31'd0, (w == 1) ? p_txd : txd}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clk_div   = 16'd4;
        p_enable  = 1'b0;
        p_clk_div = 16'd3;
        p_empty   = 1'b1;
        p_byte    = 8'h07;
        repeat (3) step();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pop", {31'd0, fifo_pop}, 32'd0);
        check("rst_p_txd", {31'd0, p_txd}, 32'd1);
        rst_n = 1'b1;
        step();

        // 0xA5 at divisor 4
        enable = 1'b1;
        push(8'hA5);
        wait_pop(0, ok);
        if (ok) frame(0, 8'hA5, 4, 1'b0, 1'b0, 1, -1, 1'b0);

        // back-to-back 0x00, 0xFF at divisor 2
        clk_div = 16'd2;
        step();
        push(8'h00);
        push(8'hFF);
        wait_pop(0, ok);
        if (ok) begin
            frame(0, 8'h00, 2, 1'b0, 1'b0, 1, -1, 1'b0);
            check("b2b_pop_with_done", {31'd0, fifo_pop}, 32'd1);
            frame(0, 8'hFF, 2, 1'b0, 1'b0, 1, -1, 1'b0);
            check("b2b_end_nopop", {31'd0, fifo_pop}, 32'd0);
        end

        // empty FIFO, enabled, 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            check("empty_pop", {31'd0, fifo_pop}, 32'd0);
            check("empty_txd", {31'd0, txd}, 32'd1);
            check("empty_busy", {31'd0, busy}, 32'd0);
            check("empty_done", {31'd0, done}, 32'd0);
        end

        // even parity, two stop bits, 0x07 at divisor 3
        p_enable = 1'b1;
        p_empty  = 1'b0;
        wait_pop(1, ok);
        if (ok) frame(1, 8'h07, 3, 1'b1, 1'b0, 2, -1, 1'b0);
        p_enable = 1'b0;

        // reset during data bit 3 of 0xA5
        clk_div = 16'd4;
        step();
        push(8'hA5);
        wait_pop(0, ok);
        if (ok) begin
            repeat (18) step();
            check("pre_rst_txd", {31'd0, txd}, 32'd0);
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_txd", {31'd0, txd}, 32'd1);
            check("async_rst_busy", {31'd0, busy}, 32'd0);
            step();
            rst_n = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                check("post_rst_pop", {31'd0, fifo_pop}, 32'd0);
                check("post_rst_txd", {31'd0, txd}, 32'd1);
                check("post_rst_busy", {31'd0, busy}, 32'd0);
            end
        end

        // divisor 0 acts as 1; mid-frame clk_div change and enable drop
        clk_div = 16'd0;
        push(8'h81);
        push(8'h55);
        wait_pop(0, ok);
        if (ok) begin
            frame(0, 8'h81, 1, 1'b0, 1'b0, 1, 8, 1'b1);
            check("disabled_pop_at_done", {31'd0, fifo_pop}, 32'd0);
            for (int i = 0; i < 5; i++) begin
                step();
                check("disabled_pop", {31'd0, fifo_pop}, 32'd0);
                check("disabled_txd", {31'd0, txd}, 32'd1);
            end
            enable = 1'b1;
            wait_pop(0, ok);
            if (ok) frame(0, 8'h55, 8, 1'b0, 1'b0, 1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
